// File: rtl/spi_memif_pkg.sv
// Shared constants, types and packet framing helpers for the SPI memory bridge.
// A packet is two halves, each {2 frame bits, half a data word}, sent MSB first.
package spi_memif_pkg;

  localparam int WORD_W       = 8;
  localparam int ADDR_W       = 2;
  localparam int PACKET_WIDTH = WORD_W + 4;
  localparam int HALF         = PACKET_WIDTH / 2;
  localparam int NIB          = WORD_W / 2;

  localparam logic [1:0] FRAME_HI = 2'b10;
  localparam logic [1:0] FRAME_LO = 2'b01;

  typedef logic [WORD_W-1:0]       word_t;
  typedef logic [PACKET_WIDTH-1:0] packet_t;

  typedef enum logic [1:0] {
    ST_RD_ADDR = 2'd0,
    ST_WR_ADDR = 2'd1,
    ST_DATA    = 2'd2
  } cmd_state_e;

  typedef struct packed {
    cmd_state_e state;
    logic       data_ready;
  } memif_dbg_t;

  function automatic packet_t pack_word(input word_t w);
    return {FRAME_HI, w[WORD_W-1:NIB], FRAME_LO, w[NIB-1:0]};
  endfunction

  function automatic word_t unpack_word(input packet_t p);
    return {p[PACKET_WIDTH-3 -: NIB], p[NIB-1:0]};
  endfunction

  function automatic logic frame_ok(input packet_t p);
    return (p[PACKET_WIDTH-1 -: 2] == FRAME_HI) && (p[HALF-1 -: 2] == FRAME_LO);
  endfunction

endpackage

// File: rtl/spi_memif_serdes.sv
// SPI mode-0 slave shifter: synchronises the pins into clk, shifts MOSI in on
// SCLK rise, raises data_ready for one clk per full packet, shifts MISO on fall.
module spi_memif_serdes
  import spi_memif_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    spi_SCLK,
  input  logic    spi_SSEL,
  input  logic    spi_MOSI,
  input  packet_t out_packet,
  output logic    spi_MISO,
  output logic    data_ready,
  output packet_t in_packet,
  output logic    ssel_idle
);

  localparam int CW = $clog2(PACKET_WIDTH);

  // [0],[1] form the synchroniser; sclk_sync[2] is the previous synced level.
  logic [2:0]    sclk_sync;
  logic [1:0]    ssel_sync;
  logic [1:0]    mosi_sync;
  logic          sclk_rise;
  logic          sclk_fall;
  logic [CW-1:0] bit_cnt;
  packet_t       rx_shift;
  packet_t       tx_shift;
  logic          load_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      ssel_sync <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_SCLK};
      ssel_sync <= {ssel_sync[0], spi_SSEL};
      mosi_sync <= {mosi_sync[0], spi_MOSI};
    end
  end

  assign ssel_idle = ssel_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign spi_MISO  = ~ssel_idle & tx_shift[PACKET_WIDTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      in_packet    <= '0;
      data_ready   <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      if (ssel_idle) begin
        bit_cnt      <= '0;
        tx_shift     <= '0;
        load_pending <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[PACKET_WIDTH-2:0], mosi_sync[1]};
          if (bit_cnt == CW'(PACKET_WIDTH - 1)) begin
            bit_cnt      <= '0;
            data_ready   <= 1'b1;
            in_packet    <= {rx_shift[PACKET_WIDTH-2:0], mosi_sync[1]};
            load_pending <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        // The fall right after a completed packet presents the reply MSB in time
        // for the master's next rising-edge sample.
        if (sclk_fall) begin
          if (load_pending) begin
            tx_shift     <= out_packet;
            load_pending <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[PACKET_WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_memif.sv
// SPI-slave bridge to a 1-clk-latency RAM: packet 1 sets the read address,
// packet 2 the write address, every later packet is written and both advance.
module spi_memif
  import spi_memif_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_SCLK,
  input  logic                  spi_SSEL,
  input  logic                  spi_MOSI,
  output logic                  spi_MISO,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WORD_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  wr_enable,
  output logic                  inPacketIsValid,
  output memif_dbg_t            dbg
);

  packet_t    in_packet;
  packet_t    out_packet;
  word_t      in_word;
  logic       data_ready;
  logic       ssel_idle;
  logic       dr_d1;
  logic       dr_d2;
  cmd_state_e state;

  spi_memif_serdes u_serdes (
    .clk        (clk),
    .reset      (reset),
    .spi_SCLK   (spi_SCLK),
    .spi_SSEL   (spi_SSEL),
    .spi_MOSI   (spi_MOSI),
    .out_packet (out_packet),
    .spi_MISO   (spi_MISO),
    .data_ready (data_ready),
    .in_packet  (in_packet),
    .ssel_idle  (ssel_idle)
  );

  assign in_word        = unpack_word(in_packet);
  assign dbg.state      = state;
  assign dbg.data_ready = data_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_RD_ADDR;
      rd_addr         <= '0;
      wr_addr         <= '0;
      wr_data         <= '0;
      wr_enable       <= 1'b0;
      inPacketIsValid <= 1'b0;
    end else begin
      wr_enable <= 1'b0;
      // wr_addr is held through the strobe cycle and steps afterwards.
      if (wr_enable) wr_addr <= wr_addr + 1'b1;
      if (ssel_idle) begin
        state           <= ST_RD_ADDR;
        inPacketIsValid <= 1'b0;
      end else if (data_ready) begin
        inPacketIsValid <= frame_ok(in_packet);
        if (frame_ok(in_packet)) begin
          case (state)
            ST_RD_ADDR: begin
              rd_addr <= in_word[ADDR_WIDTH-1:0];
              state   <= ST_WR_ADDR;
            end
            ST_WR_ADDR: begin
              wr_addr <= in_word[ADDR_WIDTH-1:0];
              state   <= ST_DATA;
            end
            ST_DATA: begin
              wr_data   <= in_word;
              wr_enable <= 1'b1;
              rd_addr   <= rd_addr + 1'b1;
            end
            default: state <= ST_RD_ADDR;
          endcase
        end
      end
    end
  end

  // Reply is captured exactly 3 clk after data_ready, so a read of the address
  // being written in the same cycle returns the old contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dr_d1      <= 1'b0;
      dr_d2      <= 1'b0;
      out_packet <= '0;
    end else if (ssel_idle) begin
      dr_d1 <= 1'b0;
      dr_d2 <= 1'b0;
    end else begin
      dr_d1 <= data_ready;
      dr_d2 <= dr_d1;
      if (dr_d2) out_packet <= pack_word(rd_data);
    end
  end

endmodule

// File: tb/tb_spi_memif.sv
// Bench for spi_memif: drives SPI sessions against a 4-word RAM and compares
// replies, RAM writes and address outputs with a packet-level reference model.
module tb_spi_memif;
  import spi_memif_pkg::*;

  localparam int W = 8;
  localparam int A = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sclk = 1'b0;
  logic         ssel = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic [A-1:0] rd_addr;
  logic [A-1:0] wr_addr;
  logic [W-1:0] rd_data;
  logic [W-1:0] wr_data;
  logic         wr_enable;
  logic         in_valid;
  memif_dbg_t   dbg;

  logic [W-1:0] ram [4] = '{default: '0};

  int checks = 0;
  int failures = 0;
  int dr_seen = 0;
  int dr_exp = 0;
  int pulse_len = 0;

  // reference model state
  logic [A+W-1:0] exp_q[$];
  logic [W-1:0]   mem_m [4] = '{default: '0};
  logic [A-1:0]   rd_m = '0;
  logic [A-1:0]   wr_m = '0;
  int             accepted = 0;
  logic [11:0]    exp_rsp = '0;
  logic [11:0]    rsp;

  // clock / reset
  always #5 clk = ~clk;

  spi_memif dut (
    .clk             (clk),
    .reset           (reset),
    .spi_SCLK        (sclk),
    .spi_SSEL        (ssel),
    .spi_MOSI        (mosi),
    .spi_MISO        (miso),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_enable       (wr_enable),
    .inPacketIsValid (in_valid),
    .dbg             (dbg)
  );

  // synchronous RAM, read latency 1, read-before-write
  always @(posedge clk) begin
    if (wr_enable) ram[wr_addr] <= wr_data;
    rd_data <= ram[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] frm(input logic [W-1:0] w);
    return {2'b10, w[7:4], 2'b01, w[3:0]};
  endfunction

  // scoreboard: every write strobe must match the next queued write, width 1 clk
  always @(negedge clk) begin
    if (dbg.data_ready) dr_seen++;
    if (wr_enable) begin
      pulse_len++;
      check("write_queued", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("write_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
    end else if (pulse_len != 0) begin
      check("wr_pulse_len", pulse_len, 1);
      pulse_len = 0;
    end
  end

  // driver tasks
  task automatic xfer(input logic [11:0] pkt, output logic [11:0] r);
    for (int i = 11; i >= 0; i--) begin
      mosi = pkt[i];
      #45 r[i] = miso;
      #5 sclk = 1'b1;
      #50 sclk = 1'b0;
    end
    #40;
  endtask

  task automatic xfer_bits(input logic [11:0] pkt, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = pkt[11-i];
      #50 sclk = 1'b1;
      #50 sclk = 1'b0;
    end
  endtask

  task automatic open_session();
    ssel = 1'b0;
    #100;
    accepted = 0;
    exp_rsp = '0;
  endtask

  task automatic close_session();
    #100 ssel = 1'b1;
    #100;
    check("idle_miso", miso, 0);
    check("idle_valid", in_valid, 0);
    check("idle_state", dbg.state, ST_RD_ADDR);
    check("idle_dready", dr_seen, dr_exp);
  endtask

  task automatic send(input logic [11:0] pkt, output logic [11:0] r);
    logic         ok;
    logic         do_wr;
    logic [W-1:0] w;
    logic [A-1:0] wa;
    logic [11:0]  want;
    ok = (pkt[11:10] == 2'b10) && (pkt[5:4] == 2'b01);
    w = {pkt[9:6], pkt[3:0]};
    do_wr = 1'b0;
    wa = wr_m;
    if (ok) begin
      if (accepted == 0) rd_m = w[A-1:0];
      else if (accepted == 1) wr_m = w[A-1:0];
      else begin
        do_wr = 1'b1;
        exp_q.push_back({wr_m, w});
        wr_m = wr_m + 1'b1;
        rd_m = rd_m + 1'b1;
      end
      if (accepted < 2) accepted++;
    end
    want = exp_rsp;
    exp_rsp = frm(mem_m[rd_m]);
    if (do_wr) mem_m[wa] = w;
    dr_exp++;
    xfer(pkt, r);
    check("reply", r, want);
    check("in_valid", in_valid, ok);
    check("rd_addr", rd_addr, rd_m);
    check("wr_addr", wr_addr, wr_m);
    check("state", dbg.state, (accepted == 0) ? ST_RD_ADDR : (accepted == 1) ? ST_WR_ADDR : ST_DATA);
    check("dready_count", dr_seen, dr_exp);
    check("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [11:0] pkt;
    int          n;

    repeat (3) @(posedge clk);
    #2;
    check("rst_miso", miso, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_enable", wr_enable, 0);
    check("rst_valid", in_valid, 0);
    check("rst_state", dbg.state, ST_RD_ADDR);
    reset = 1'b1;
    #100;

    // clocking with SSEL high: silent, nothing received
    xfer(frm(8'h5A), rsp);
    check("ssel_high_miso", rsp, 0);
    check("ssel_high_dready", dr_seen, 0);

    // write A5 to address 1
    open_session();
    send(frm(8'h00), rsp);
    send(frm(8'h01), rsp);
    send(frm(8'hA5), rsp);
    close_session();
    check("mem1_a5", ram[1], 8'hA5);

    // preload mem[2]=3C, then read it back as the third reply
    open_session();
    send(frm(8'h00), rsp);
    send(frm(8'h02), rsp);
    send(frm(8'h3C), rsp);
    close_session();
    open_session();
    send(frm(8'h02), rsp);
    send(frm(8'h00), rsp);
    send(frm(W'($urandom_range(0, 255))), rsp);
    check("read_mem2", rsp, frm(8'h3C));
    close_session();

    // five data packets from write address 3 wrap through 3,0,1,2,3
    open_session();
    send(frm(W'($urandom_range(0, 255))), rsp);
    send(frm(8'h03), rsp);
    for (int i = 0; i < 5; i++) send(frm(W'($urandom_range(0, 255))), rsp);
    check("wrap_wr_addr", wr_addr, 0);
    close_session();

    // bad frame between commands leaves state and addresses alone
    open_session();
    send(frm(8'h01), rsp);
    send(12'h000, rsp);
    check("bad_frame_valid", in_valid, 0);
    check("bad_frame_rd_addr", rd_addr, 1);
    send(frm(8'h02), rsp);
    send(frm(W'($urandom_range(0, 255))), rsp);
    close_session();

    // abort after 6 bits: partial packet discarded, fresh session at RD_ADDR
    open_session();
    xfer_bits(frm(8'hFF), 6);
    #100 ssel = 1'b1;
    #100;
    check("abort_dready", dr_seen, dr_exp);
    check("abort_state", dbg.state, ST_RD_ADDR);
    open_session();
    send(frm(W'($urandom_range(0, 255))), rsp);
    send(frm(W'($urandom_range(0, 255))), rsp);
    send(frm(W'($urandom_range(0, 255))), rsp);
    close_session();

    // random sessions with occasional corrupted frames
    for (int s = 0; s < 4; s++) begin
      open_session();
      n = $urandom_range(3, 7);
      for (int p = 0; p < n; p++) begin
        if ($urandom_range(0, 5) == 0) pkt = 12'($urandom_range(0, 4095));
        else pkt = frm(W'($urandom_range(0, 255)));
        send(pkt, rsp);
      end
      close_session();
    end

    for (int i = 0; i < 4; i++) check("final_ram", ram[i], mem_m[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
